multdiv_sequencer: RTL and testbench
====================================

# multdiv_sequencer

Controller that sequences the shared multi-cycle multiply/divide unit from the execute stage of the pipelined processor. It detects an R-type MUL or DIV in X, freezes the front of the pipeline, issues the start pulse to the unit, waits for its ready flag (bounded by a timeout), and writes the result to `rd`. On exception or timeout it writes the status code to `$r30` instead. It sits beside the X-stage ALU and drives the register-file side-write port and the F/D/X stall line.

## Interface
- `TIMEOUT`, 40: maximum BUSY cycles before a forced exception; legal range 2..255.
- `RSTATUS`, 30: register index written on exception.
- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `x_valid`  in  1  X stage holds a real instruction.
- `x_opcode`  in  5  X-stage opcode field.
- `x_aluop`  in  5  X-stage ALU op field.
- `x_rd`  in  5  X-stage destination register.
- `x_flush`  in  1  squash X (taken branch/jump from an older instruction).
- `md_rdy`  in  1  unit result valid (single-cycle pulse).
- `md_exc`  in  1  unit exception, sampled with `md_rdy`.
- `md_result`  in  32  unit result, sampled with `md_rdy`.
- `ctrl_mult`  out  1  one-cycle start pulse, multiply.
- `ctrl_div`  out  1  one-cycle start pulse, divide.
- `stall`  out  1  freeze PC, F/D and D/X latches.
- `md_we`  out  1  side-write enable to the register file.
- `md_waddr`  out  5  side-write address.
- `md_wdata`  out  32  side-write data.
- `busy`  out  1  state is not IDLE.

## Operation
- Decode: `is_md = x_valid & ~x_flush & (x_opcode==5'b00000) & (x_aluop==5'b00110 | x_aluop==5'b00111)`. Aluop 00110 selects MUL, 00111 selects DIV.
- States: IDLE, START, BUSY, WB. All state, counter and output registers are asynchronously cleared by `resetn`=0.
- IDLE:
  - If `is_md`: latch op type and `x_rd`, assert `stall` combinationally, and go to START.
  - Otherwise stay. `stall`=0.
- START: assert exactly one of `ctrl_mult`/`ctrl_div` for this single cycle. `stall`=1. Clear the 8-bit counter and go to BUSY. `md_rdy` is ignored in this cycle.
- BUSY:
  - `stall`=1. The counter increments each cycle.
  - If `md_rdy`: latch `md_exc`/`md_result` and go to WB.
  - Else if the counter equals `TIMEOUT`-1: latch a forced exception and go to WB.
  - `md_rdy` wins over a timeout in the same cycle.
- WB:
  - `stall`=0, so X advances at the end of this cycle and the instruction is not re-accepted.
  - If the latched exception is set: `md_we`=1, `md_waddr`=`RSTATUS`, `md_wdata`=4 for MUL or 5 for DIV, zero-extended to 32 bits.
  - Otherwise: `md_waddr`=latched rd, `md_wdata`=latched result, `md_we`=(rd!=0).
  - Go to IDLE.
- `x_flush` in START or BUSY: return to IDLE next cycle. `stall` drops in the flush cycle, no write occurs, and any later `md_rdy` is ignored.
- `x_flush` in WB has no effect; the write completes.
- A `md_rdy` arriving while in IDLE is ignored.

## Timing
- Reset values: `ctrl_mult`, `ctrl_div`, `md_we`, `busy` = 0; `md_waddr`, `md_wdata` = 0; state is IDLE.
- `stall` follows the relations below.
- `ctrl_*`, `md_we`, `md_waddr`, `md_wdata` and `busy` are registered or state-decoded, with no combinational path from inputs.
- `stall` is combinational from the IDLE-accept decode and from `x_flush`.
- Latency with accept in cycle T:
  - Start pulse in T+1.
  - A unit ready N cycles after the pulse (N≥1) means `md_rdy` arrives in T+1+N.
  - The write is in T+2+N. `stall` is high for cycles T..T+1+N.
- Timeout: WB occurs at T+2+`TIMEOUT` when no `md_rdy` arrives.
- Back-to-back MUL/DIV: the second is accepted in the cycle after WB, with one bubble-free handoff.
- `resetn` asserted mid-operation: the block returns to IDLE immediately, with no write and no pulse.

## Test plan
- MUL r3=r1*r2, unit ready 32 cycles after pulse -> pulse at T+1, `stall` high T..T+33, `md_we`=1, `md_waddr`=3, `md_wdata`=result at T+34.
- DIV with `md_exc`=1 on ready -> write at WB with `md_waddr`=30, `md_wdata`=5; rd untouched.
- `TIMEOUT`=8, `md_rdy` never asserts -> WB at T+10 writes `$r30`=4 for MUL; `md_rdy` at T+12 is ignored.
- MUL with rd=0, no exception -> `md_we`=0 in WB; `stall` still releases at WB.
- `x_flush` in the 5th BUSY cycle -> `stall` low in that cycle, IDLE next, no write; a late `md_rdy` causes nothing.
- `resetn` pulsed low during BUSY -> all outputs 0 asynchronously; a following MUL is accepted normally.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the shared multi-cycle multiply/divide unit:
// accepts MUL/DIV in X, stalls the front end, pulses start, waits for ready or timeout, writes back.
module multdiv_sequencer #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned RSTATUS = 30
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        x_valid,
    input  logic [4:0]  x_opcode,
    input  logic [4:0]  x_aluop,
    input  logic [4:0]  x_rd,
    input  logic        x_flush,
    input  logic        md_rdy,
    input  logic        md_exc,
    input  logic [31:0] md_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        md_we,
    output logic [4:0]  md_waddr,
    output logic [31:0] md_wdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, START, BUSY, WB} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);
    localparam logic [4:0] STATUS_REG = 5'(RSTATUS);

    state_t      state;
    state_t      state_next;
    logic        is_md;
    logic        timeout_hit;
    logic        op_div;
    logic [4:0]  rd_q;
    logic        exc_q;
    logic [31:0] result_q;
    logic [7:0]  count;

    assign is_md = x_valid & ~x_flush & (x_opcode == 5'b00000)
                 & ((x_aluop == 5'b00110) | (x_aluop == 5'b00111));
    assign timeout_hit = (count == LAST_COUNT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush outranks both ready and timeout; ready outranks timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (is_md) state_next = START;
            START: state_next = x_flush ? IDLE : BUSY;
            BUSY: begin
                if (x_flush) begin
                    state_next = IDLE;
                end else if (md_rdy || timeout_hit) begin
                    state_next = WB;
                end
            end
            WB:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_div   <= 1'b0;
            rd_q     <= '0;
            exc_q    <= 1'b0;
            result_q <= '0;
            count    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_md) begin
                        op_div <= x_aluop[0];
                        rd_q   <= x_rd;
                    end
                end
                START: count <= '0;
                BUSY: begin
                    count <= count + 8'd1;
                    if (md_rdy) begin
                        exc_q    <= md_exc;
                        result_q <= md_result;
                    end else if (timeout_hit) begin
                        exc_q <= 1'b1;
                    end
                end
                WB: ;
            endcase
        end
    end

    always_comb begin
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        stall     = 1'b0;
        md_we     = 1'b0;
        md_waddr  = '0;
        md_wdata  = '0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE:  stall = is_md;
            START: begin
                stall     = ~x_flush;
                ctrl_mult = ~op_div;
                ctrl_div  = op_div;
            end
            BUSY:  stall = ~x_flush;
            WB: begin
                if (exc_q) begin
                    md_we    = 1'b1;
                    md_waddr = STATUS_REG;
                    md_wdata = op_div ? 32'd5 : 32'd4;
                end else begin
                    md_we    = (rd_q != 5'd0);
                    md_waddr = rd_q;
                    md_wdata = result_q;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized bench for multdiv_sequencer; expected outputs derived per cycle from accept-relative timing.
module tb_multdiv_sequencer;

    localparam int TO = 40;
    localparam int RS = 30;

    logic        clock = 1'b0;
    logic        resetn;
    logic        x_valid;
    logic [4:0]  x_opcode;
    logic [4:0]  x_aluop;
    logic [4:0]  x_rd;
    logic        x_flush;
    logic        md_rdy;
    logic        md_exc;
    logic [31:0] md_result;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        md_we;
    logic [4:0]  md_waddr;
    logic [31:0] md_wdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multdiv_sequencer #(.TIMEOUT(TO), .RSTATUS(RS)) dut (
        .clock(clock), .resetn(resetn), .x_valid(x_valid), .x_opcode(x_opcode),
        .x_aluop(x_aluop), .x_rd(x_rd), .x_flush(x_flush), .md_rdy(md_rdy),
        .md_exc(md_exc), .md_result(md_result), .ctrl_mult(ctrl_mult),
        .ctrl_div(ctrl_div), .stall(stall), .md_we(md_we), .md_waddr(md_waddr),
        .md_wdata(md_wdata), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input int id, input int k, input logic stall_e, input logic mult_e,
                              input logic div_e, input logic we_e, input logic [4:0] waddr_e,
                              input logic [31:0] wdata_e, input logic busy_e);
        check($sformatf("t%0d.k%0d.stall", id, k), {31'b0, stall}, {31'b0, stall_e});
        check($sformatf("t%0d.k%0d.ctrl_mult", id, k), {31'b0, ctrl_mult}, {31'b0, mult_e});
        check($sformatf("t%0d.k%0d.ctrl_div", id, k), {31'b0, ctrl_div}, {31'b0, div_e});
        check($sformatf("t%0d.k%0d.md_we", id, k), {31'b0, md_we}, {31'b0, we_e});
        check($sformatf("t%0d.k%0d.md_waddr", id, k), {27'b0, md_waddr}, {27'b0, waddr_e});
        check($sformatf("t%0d.k%0d.md_wdata", id, k), md_wdata, wdata_e);
        check($sformatf("t%0d.k%0d.busy", id, k), {31'b0, busy}, {31'b0, busy_e});
    endtask

    task automatic junk_x;
        x_valid  = 1'b0;
        x_opcode = 5'($urandom);
        x_aluop  = 5'($urandom);
        x_rd     = 5'($urandom);
    endtask

    // Idle cycles with traffic that must never be accepted: invalid, flushed, or non-MUL/DIV ops.
    task automatic idle_cycles(input int id, input int cnt);
        for (int c = 0; c < cnt; c++) begin
            @(negedge clock);
            case ($urandom_range(0, 2))
                0: begin
                    junk_x();
                    x_flush = 1'($urandom);
                end
                1: begin
                    x_valid  = 1'b1;
                    x_opcode = 5'd0;
                    x_aluop  = $urandom_range(0, 1) ? 5'd7 : 5'd6;
                    x_rd     = 5'($urandom);
                    x_flush  = 1'b1;
                end
                default: begin
                    x_valid  = 1'b1;
                    x_opcode = 5'($urandom);
                    x_aluop  = 5'($urandom);
                    if (x_opcode == 5'd0 && (x_aluop == 5'd6 || x_aluop == 5'd7)) x_aluop = 5'd0;
                    x_rd     = 5'($urandom);
                    x_flush  = 1'($urandom);
                end
            endcase
            md_rdy    = 1'($urandom);
            md_exc    = 1'($urandom);
            md_result = $urandom;
            #2;
            check_outs(id, -1 - c, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        end
    endtask

    // One MUL/DIV accepted at k=0; unit ready n cycles after the start pulse (n>TO means it misses the timeout).
    // flush_at / reset_at < 0 disable those events.
    task automatic run_txn(input int id, input bit div, input logic [4:0] rd, input int n,
                           input bit exc, input logic [31:0] res, input int flush_at,
                           input int reset_at, input bit b2b);
        int  w;
        int  last;
        int  kill_r;
        int  busy_last;
        bit  fl;
        bit  rs;
        bit  timed_out;
        bit  exc_eff;
        bit  present;
        bit  wr;
        logic stall_e, busy_e, pulse_e, we_e;
        logic [4:0]  waddr_e;
        logic [31:0] wdata_e;

        timed_out = (n > TO);
        exc_eff   = timed_out || exc;
        w         = timed_out ? 2 + TO : 2 + n;
        fl        = (flush_at >= 0);
        rs        = (reset_at >= 0);
        last      = b2b ? w : (((1 + n) > w ? 1 + n : w) + 1);
        kill_r    = rs ? reset_at : 1_000_000;
        busy_last = fl ? flush_at : w;

        for (int k = 0; k <= last; k++) begin
            @(negedge clock);
            present = (k <= w) && !(fl && k > flush_at) && !(rs && k >= reset_at);
            if (present) begin
                x_valid  = 1'b1;
                x_opcode = 5'd0;
                x_aluop  = div ? 5'd7 : 5'd6;
                x_rd     = rd;
            end else begin
                junk_x();
            end
            x_flush = fl && (k == flush_at);
            resetn  = !(rs && k == reset_at);
            md_rdy  = (k == 1 + n);
            if (md_rdy) begin
                md_exc    = exc;
                md_result = res;
            end else begin
                md_exc    = 1'($urandom);
                md_result = $urandom;
            end
            #2;
            stall_e = (k < busy_last) && (k < kill_r);
            busy_e  = (k >= 1) && (k <= busy_last) && (k < kill_r);
            pulse_e = (k == 1) && (1 < kill_r);
            wr      = (k == w) && !fl && (w < kill_r);
            we_e    = wr && (exc_eff || rd != 5'd0);
            waddr_e = wr ? (exc_eff ? 5'(RS) : rd) : 5'd0;
            wdata_e = wr ? (exc_eff ? (div ? 32'd5 : 32'd4) : res) : 32'd0;
            check_outs(id, k, stall_e, pulse_e && !div, pulse_e && div, we_e, waddr_e, wdata_e, busy_e);
        end
    endtask

    initial begin
        int  n, fa, ra;
        bit  b2b, prev_b2b;
        int  w;

        resetn = 1'b0;
        junk_x();
        x_flush = 1'b0;
        md_rdy = 1'b0;
        md_exc = 1'b0;
        md_result = '0;
        #3;
        check_outs(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        idle_cycles(0, 4);

        run_txn(1, 1'b0, 5'd3, 32, 1'b0, $urandom, -1, -1, 1'b0);
        idle_cycles(1, 2);
        run_txn(2, 1'b1, 5'd9, 5, 1'b1, $urandom, -1, -1, 1'b0);
        run_txn(3, 1'b0, 5'd7, TO + 2, 1'b0, $urandom, -1, -1, 1'b0);
        run_txn(4, 1'b0, 5'd0, 3, 1'b0, $urandom, -1, -1, 1'b0);
        run_txn(5, 1'b0, 5'd12, 20, 1'b0, $urandom, 6, -1, 1'b0);
        run_txn(6, 1'b1, 5'd14, 20, 1'b0, $urandom, -1, 10, 1'b0);
        run_txn(7, 1'b0, 5'd5, 1, 1'b0, $urandom, -1, -1, 1'b0);
        run_txn(8, 1'b0, 5'd4, 4, 1'b0, $urandom, -1, -1, 1'b1);
        run_txn(9, 1'b1, 5'd6, 2, 1'b0, $urandom, -1, -1, 1'b0);
        run_txn(10, 1'b1, 5'd8, TO, 1'b0, $urandom, -1, -1, 1'b0);
        run_txn(11, 1'b1, 5'd8, TO + 1, 1'b0, $urandom, -1, -1, 1'b0);
        run_txn(12, 1'b0, 5'd1, 6, 1'b0, $urandom, 1, -1, 1'b0);

        prev_b2b = 1'b0;
        for (int t = 100; t < 160; t++) begin
            if (!prev_b2b) idle_cycles(t, $urandom_range(0, 3));
            n  = $urandom_range(1, TO + 3);
            w  = (n > TO) ? 2 + TO : 2 + n;
            fa = -1;
            ra = -1;
            case ($urandom_range(0, 9))
                0, 1: fa = $urandom_range(1, w - 1);
                2:    ra = $urandom_range(2, w);
                default: ;
            endcase
            b2b = (fa < 0) && (ra < 0) && (n <= TO) && ($urandom_range(0, 2) == 0);
            run_txn(t, 1'($urandom), 5'($urandom), n, ($urandom_range(0, 3) == 0),
                    $urandom, fa, ra, b2b);
            prev_b2b = b2b;
        end
        idle_cycles(200, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
